// File: rtl/uart_rx_param.sv
// 16x-oversampled UART receiver with start-bit validation, framing check and a show-ahead FIFO.
// Define UART_RX_PARITY_EN to add one parity bit per frame, with its sense set by PARITY_ODD.
module uart_rx_param #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            rx_data,
    output logic [DATA_BITS-1:0]            data_out,
    output logic                            data_valid,
    input  logic                            data_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            frame_err,
    output logic                            parity_err,
    output logic                            overrun,
    output logic [7:0]                      overrun_cnt
);

    localparam int unsigned DIV = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LW  = AW + 1;

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_param: DATA_BITS must be in 5..9");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
    begin : g_bad_depth
        $error("uart_rx_param: FIFO_DEPTH must be a power of two in 2..256");
    end
    if (PARITY_ODD > 1) begin : g_bad_parity
        $error("uart_rx_param: PARITY_ODD must be 0 or 1");
    end
    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_param: CLK_HZ too low for 16x oversampling at BAUD");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    // Input synchroniser and edge history
    logic rx_meta_q, rx_s_q, rx_prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_data;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    state_e               state_q;
    logic [PW-1:0]        presc_q;
    logic [3:0]           cnt_q;
    logic [3:0]           bits_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 frame_err_q, overrun_q;
    logic [7:0]           overrun_cnt_q;

    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]        level_q;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

    logic start_edge, tick, sample_pt, stop_hit, good, fifo_full, pop, push, drop;

    assign start_edge = (state_q == StIdle) && rx_prev_q && !rx_s_q;
    assign tick       = (presc_q == PW'(DIV - 1));
    assign sample_pt  = tick && (cnt_q == 4'd15);
    assign stop_hit   = (state_q == StStop) && sample_pt;

`ifdef UART_RX_PARITY_EN
    localparam logic ParOdd = (PARITY_ODD != 0);
    logic par_bit_q, parity_ok, parity_err_q;
    assign parity_ok  = ((^shreg_q) ^ par_bit_q) == ParOdd;
    assign good       = stop_hit && rx_s_q && parity_ok;
    assign parity_err = parity_err_q;
`else
    assign good       = stop_hit && rx_s_q;
    assign parity_err = 1'b0;
`endif

    assign data_valid = (level_q != '0);
    assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
    assign pop        = data_valid && data_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign push       = good && (!fifo_full || pop);
    assign drop       = good && fifo_full && !pop;

    // Prescaler restarts on the start edge so sampling is phase-aligned to the frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else if (start_edge || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            bits_q        <= '0;
            shreg_q       <= '0;
            frame_err_q   <= 1'b0;
            overrun_q     <= 1'b0;
            overrun_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit_q     <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            frame_err_q <= stop_hit && !rx_s_q;
            overrun_q   <= drop;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= stop_hit && rx_s_q && !parity_ok;
`endif
            if (drop && (overrun_cnt_q != 8'hff)) begin
                overrun_cnt_q <= overrun_cnt_q + 8'd1;
            end
            if (tick) begin
                cnt_q <= cnt_q + 4'd1;
            end
            case (state_q)
                StIdle: begin
                    if (start_edge) begin
                        state_q <= StStart;
                        cnt_q   <= '0;
                    end
                end
                StStart: begin
                    // Mid start bit: a high line here was only a glitch
                    if (tick && (cnt_q == 4'd7)) begin
                        cnt_q  <= '0;
                        bits_q <= '0;
                        state_q <= rx_s_q ? StIdle : StData;
                    end
                end
                StData: begin
                    if (sample_pt) begin
                        shreg_q <= {rx_s_q, shreg_q[DATA_BITS-1:1]};
                        bits_q  <= bits_q + 4'd1;
                        if (bits_q == 4'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end
                    end
                end
                StParity: begin
`ifdef UART_RX_PARITY_EN
                    if (sample_pt) begin
                        par_bit_q <= rx_s_q;
                        state_q   <= StStop;
                    end
`else
                    state_q <= StIdle;
`endif
                end
                StStop: begin
                    if (sample_pt) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= shreg_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Head is masked while empty so data_out reads 0 out of reset
    assign data_out    = data_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level  = level_q;
    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;
    assign overrun_cnt = overrun_cnt_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param; clock is scaled to 128x BAUD so each bit spans 128 clocks.
// Build with UART_RX_PARITY_EN defined to also exercise the even-parity path.
module tb_uart_rx_param;

    localparam int unsigned BAUD      = 115200;
    localparam int unsigned CLK_HZ    = BAUD * 128;
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned BIT_CLKS  = 128;
    localparam int unsigned FAST_CLKS = 124;  // transmitter 3% fast
    localparam int unsigned SLOW_CLKS = 132;  // transmitter 3% slow
    localparam int unsigned TICK_CLKS = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 rx_data = 1'b1;
    logic                 data_ready = 1'b0;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic [4:0]           fifo_level;
    logic                 frame_err, parity_err, overrun;
    logic [7:0]           overrun_cnt;

    uart_rx_param #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (DEPTH),
        .PARITY_ODD (0)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_data     (rx_data),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .fifo_level  (fifo_level),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt)
    );

    always #10 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fe = 0, n_pe = 0, n_ov = 0;
    logic [7:0]  exp_q[$];

    // Count high cycles, so a stretched pulse shows up as an extra count
    always @(negedge clk) begin
        if (frame_err)  n_fe++;
        if (parity_err) n_pe++;
        if (overrun)    n_ov++;
    end

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int unsigned bclk, input logic stop_val,
                              input logic par_val, input bit expect_push);
        if (expect_push) exp_q.push_back(d);
        rx_data = 1'b0;
        wait_clks(bclk);
        for (int i = 0; i < int'(DATA_BITS); i++) begin
            rx_data = d[i];
            wait_clks(bclk);
        end
        if (PAR_EN) begin
            rx_data = par_val;
            wait_clks(bclk);
        end
        rx_data = stop_val;
        wait_clks(bclk);
        rx_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_frame(d, BIT_CLKS, 1'b1, ^d, 1'b1);
    endtask

    task automatic drain(input string tag);
        int unsigned guard = 0;
        int unsigned e;
        while (data_valid && guard < 2 * DEPTH) begin
            e = (exp_q.size() != 0) ? int'(exp_q.pop_front()) : 32'hdead;
            check_eq(tag, data_out, e);
            data_ready = 1'b1;
            wait_clks(1);
            data_ready = 1'b0;
            guard++;
        end
        check_eq({tag, " left"}, exp_q.size(), 0);
        check_eq({tag, " valid"}, data_valid, 0);
        check_eq({tag, " level"}, fifo_level, 0);
    endtask

    int unsigned fe0, pe0, ov0;

    initial begin
        wait_clks(5);
        check_eq("rst data_out", data_out, 0);
        check_eq("rst valid", data_valid, 0);
        check_eq("rst level", fifo_level, 0);
        check_eq("rst ovcnt", overrun_cnt, 0);
        check_eq("rst errs", {frame_err, parity_err, overrun}, 0);
        reset_n = 1'b1;
        wait_clks(5);

        // Single byte held, then one pop
        send_byte(8'hA5);
        wait_clks(5);
        check_eq("a5 valid", data_valid, 1);
        check_eq("a5 data", data_out, 8'hA5);
        check_eq("a5 level", fifo_level, 1);
        check_eq("a5 errs", n_fe + n_pe + n_ov, 0);
        drain("a5");

        // 17 back-to-back bytes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), BIT_CLKS, 1'b1, ^(8'(i)), i < 16);
        end
        wait_clks(5);
        check_eq("fill level", fifo_level, 16);
        check_eq("fill overrun pulses", n_ov, 1);
        check_eq("fill ovcnt", overrun_cnt, 1);
        check_eq("fill fe", n_fe, 0);
        drain("fill");

        // Stop bit low
        fe0 = n_fe;
        send_frame(8'h3C, BIT_CLKS, 1'b0, ^(8'h3C), 1'b0);
        wait_clks(BIT_CLKS);
        check_eq("fe pulses", n_fe - fe0, 1);
        check_eq("fe level", fifo_level, 0);
        send_byte(8'h55);
        wait_clks(5);
        drain("after fe");
        check_eq("fe once", n_fe - fe0, 1);

        // Short glitch on idle line
        fe0 = n_fe; pe0 = n_pe; ov0 = n_ov;
        rx_data = 1'b0;
        wait_clks(3 * TICK_CLKS);
        rx_data = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check_eq("glitch level", fifo_level, 0);
        check_eq("glitch errs", (n_fe - fe0) + (n_pe - pe0) + (n_ov - ov0), 0);

        // Baud mismatch both ways
        send_frame(8'h81, FAST_CLKS, 1'b1, ^(8'h81), 1'b1);
        wait_clks(BIT_CLKS);
        send_frame(8'h81, SLOW_CLKS, 1'b1, ^(8'h81), 1'b1);
        wait_clks(5);
        check_eq("skew level", fifo_level, 2);
        check_eq("skew errs", (n_fe - fe0) + (n_pe - pe0) + (n_ov - ov0), 0);
        drain("skew");

`ifdef UART_RX_PARITY_EN
        pe0 = n_pe;
        send_frame(8'h07, BIT_CLKS, 1'b1, 1'b1, 1'b1);
        wait_clks(5);
        check_eq("par good pe", n_pe - pe0, 0);
        send_frame(8'h07, BIT_CLKS, 1'b1, 1'b0, 1'b0);
        wait_clks(5);
        check_eq("par bad pe", n_pe - pe0, 1);
        check_eq("par level", fifo_level, 1);
        drain("parity");
`else
        check_eq("parity tied", n_pe, 0);
`endif

        // Reset with FIFO contents and a frame in flight
        send_byte(8'h11);
        send_byte(8'h22);
        rx_data = 1'b0;
        wait_clks(BIT_CLKS);
        rx_data = 1'b1;
        wait_clks(BIT_CLKS / 2);
        reset_n = 1'b0;
        exp_q.delete();
        wait_clks(1);
        check_eq("midrst level", fifo_level, 0);
        check_eq("midrst valid", data_valid, 0);
        check_eq("midrst data", data_out, 0);
        check_eq("midrst ovcnt", overrun_cnt, 0);
        wait_clks(3);
        reset_n = 1'b1;
        wait_clks(BIT_CLKS * 10);
        check_eq("postrst level", fifo_level, 0);
        send_byte(8'h5A);
        wait_clks(5);
        check_eq("postrst data", data_out, 8'h5A);
        drain("postrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
